// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- bus bundle for the multi-port register file.
//
// Groups the two read ports (address in, data/busy out), the two write ports
// (port 0 = ALU writeback, port 1 = load writeback) and the issue-time
// busy-set request.
//   master : pipeline side, drives addresses/writes, receives read data/busy
//   slave  : register file side
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;

  logic            RegWEn0;
  logic [AW-1:0]   rd0_addr;
  logic [XLEN-1:0] rd0_data;

  logic            RegWEn1;
  logic [AW-1:0]   rd1_addr;
  logic [XLEN-1:0] rd1_data;

  logic            busy_set;
  logic [AW-1:0]   busy_addr;

  modport master (
    output rs1_addr, rs2_addr,
    output RegWEn0, rd0_addr, rd0_data,
    output RegWEn1, rd1_addr, rd1_data,
    output busy_set, busy_addr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy
  );

  modport slave (
    input  rs1_addr, rs2_addr,
    input  RegWEn0, rd0_addr, rd0_data,
    input  RegWEn1, rd1_addr, rd1_data,
    input  busy_set, busy_addr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp -- 2-read / 2-write register file with per-register busy
// (pending-write) scoreboard bits.
//
// Ports:
//   clk    : sole clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset, clears registers and busy bits
//   bus    : regfile_mp_if.slave
//              rs1/rs2 read ports (combinational data + busy)
//              write port 0 (RegWEn0/rd0_*) -- ALU writeback, wins on conflict
//              write port 1 (RegWEn1/rd1_*) -- load writeback, clears busy
//              busy_set/busy_addr            -- marks a register pending at issue
//
// Register 0 reads as zero and is never written; its busy bit is always 0.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data (and the resulting busy state) to the read ports. Without it, reads
// reflect stored state only.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;

  logic wr0_en, wr1_en, set_en;

  assign wr0_en = bus.RegWEn0 && (bus.rd0_addr != '0);
  assign wr1_en = bus.RegWEn1 && (bus.rd1_addr != '0);
  assign set_en = bus.busy_set && (bus.busy_addr != '0);

  // Port 1 is applied first so that port 0 overrides it on an address clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr1_en) regs[bus.rd1_addr] <= bus.rd1_data;
      if (wr0_en) regs[bus.rd0_addr] <= bus.rd0_data;
    end
  end

  // Clear before set: a same-cycle set and clear of one register leaves it busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wr1_en) busy[bus.rd1_addr]  <= 1'b0;
      if (set_en) busy[bus.busy_addr] <= 1'b1;
    end
  end

  logic [AW-1:0] rs_addr [2];
  assign rs_addr[0] = bus.rs1_addr;
  assign rs_addr[1] = bus.rs2_addr;

  for (genvar g = 0; g < 2; g++) begin : g_rd
    logic [XLEN-1:0] data;
    logic            bsy;

    always_comb begin
      data = regs[rs_addr[g]];
      bsy  = busy[rs_addr[g]];
`ifdef REGFILE_BYPASS_EN
      if (wr1_en && (bus.rd1_addr == rs_addr[g])) begin
        data = bus.rd1_data;
        bsy  = set_en && (bus.busy_addr == rs_addr[g]);
      end
      if (wr0_en && (bus.rd0_addr == rs_addr[g])) begin
        data = bus.rd0_data;
      end
`endif
      // Address 0 and reset force zero regardless of stored or bypassed state.
      if ((rs_addr[g] == '0) || !rst_n) begin
        data = '0;
        bsy  = 1'b0;
      end
    end
  end

  assign bus.rs1_data = g_rd[0].data;
  assign bus.rs1_busy = g_rd[0].bsy;
  assign bus.rs2_data = g_rd[1].data;
  assign bus.rs2_busy = g_rd[1].bsy;
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [XLEN-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [XLEN-1:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected an entry", obs);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert (obs === e.val)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    bus.RegWEn0   = 1'b0;
    bus.rd0_addr  = '0;
    bus.rd0_data  = '0;
    bus.RegWEn1   = 1'b0;
    bus.rd1_addr  = '0;
    bus.rd1_data  = '0;
    bus.busy_set  = 1'b0;
    bus.busy_addr = '0;
  endtask

  // Advance one edge and leave inputs settling 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                            input logic b1, input string tag);
    bus.rs1_addr = a1;
    #1;
    push({tag, "_data"}, d1);
    check(bus.rs1_data);
    push({tag, "_busy"}, {{(XLEN-1){1'b0}}, b1});
    check({{(XLEN-1){1'b0}}, bus.rs1_busy});
  endtask

  initial begin
    logic [AW-1:0] a;
    idle();
    bus.rs1_addr = 5'd9;
    bus.rs2_addr = 5'd3;

    // Outputs held at zero during reset.
    tick();
    push("rst_rs1_data", '0);  check(bus.rs1_data);
    push("rst_rs2_data", '0);  check(bus.rs2_data);
    push("rst_rs1_busy", '0);  check({31'b0, bus.rs1_busy});
    push("rst_rs2_busy", '0);  check({31'b0, bus.rs2_busy});

    // Writes presented while reset is held must be discarded.
    bus.RegWEn0  = 1'b1; bus.rd0_addr = 5'd4; bus.rd0_data = 32'hCAFE0004;
    bus.busy_set = 1'b1; bus.busy_addr = 5'd4;
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    // Every address reads zero / not busy after reset.
    for (int i = 0; i < NREGS; i++) begin
      a = AW'(i);
      bus.rs1_addr = a;
      bus.rs2_addr = AW'(NREGS - 1 - i);
      #1;
      push("post_rst_rs1_data", '0); check(bus.rs1_data);
      push("post_rst_rs2_data", '0); check(bus.rs2_data);
      push("post_rst_rs1_busy", '0); check({31'b0, bus.rs1_busy});
      push("post_rst_rs2_busy", '0); check({31'b0, bus.rs2_busy});
    end

    // Write to x0 is ignored.
    bus.RegWEn0 = 1'b1; bus.rd0_addr = '0; bus.rd0_data = 32'hDEADBEEF;
    tick();
    idle();
    read_check(5'd0, 32'h0, 1'b0, "x0_write");

    // Port 0 wins a same-address clash; port 1 still clears busy.
    bus.busy_set = 1'b1; bus.busy_addr = 5'd5;
    tick();
    idle();
    read_check(5'd5, 32'h0, 1'b1, "busy5_set");
    bus.RegWEn0 = 1'b1; bus.rd0_addr = 5'd5; bus.rd0_data = 32'h11111111;
    bus.RegWEn1 = 1'b1; bus.rd1_addr = 5'd5; bus.rd1_data = 32'h22222222;
    tick();
    idle();
    read_check(5'd5, 32'h11111111, 1'b0, "clash5");

    // Distinct addresses: both writes land.
    bus.RegWEn0 = 1'b1; bus.rd0_addr = 5'd6; bus.rd0_data = 32'h66666666;
    bus.RegWEn1 = 1'b1; bus.rd1_addr = 5'd8; bus.rd1_data = 32'h88888888;
    tick();
    idle();
    read_check(5'd6, 32'h66666666, 1'b0, "dual_wr6");
    read_check(5'd8, 32'h88888888, 1'b0, "dual_wr8");

    // Busy set then cleared by a load writeback.
    bus.busy_set = 1'b1; bus.busy_addr = 5'd7;
    tick();
    idle();
    read_check(5'd7, 32'h0, 1'b1, "busy7_set");
    bus.RegWEn1 = 1'b1; bus.rd1_addr = 5'd7; bus.rd1_data = 32'hA5A5A5A5;
    tick();
    idle();
    read_check(5'd7, 32'hA5A5A5A5, 1'b0, "busy7_clr");

    // Set and clear together: set wins.
    bus.busy_set = 1'b1; bus.busy_addr = 5'd10;
    bus.RegWEn1  = 1'b1; bus.rd1_addr = 5'd10; bus.rd1_data = 32'h0000000A;
    tick();
    idle();
    read_check(5'd10, 32'h0000000A, 1'b1, "set_clr10");

    // Port 0 write does not clear busy.
    bus.busy_set = 1'b1; bus.busy_addr = 5'd11;
    tick();
    idle();
    bus.RegWEn0 = 1'b1; bus.rd0_addr = 5'd11; bus.rd0_data = 32'h0B0B0B0B;
    tick();
    idle();
    read_check(5'd11, 32'h0B0B0B0B, 1'b1, "p0_keeps_busy11");

    // busy_set to x0 is ignored.
    bus.busy_set = 1'b1; bus.busy_addr = '0;
    tick();
    idle();
    read_check(5'd0, 32'h0, 1'b0, "busy_x0");

    // Same-cycle write/read of register 3.
    bus.rs2_addr = 5'd3;
    bus.RegWEn0 = 1'b1; bus.rd0_addr = 5'd3; bus.rd0_data = 32'h12345678;
    #1;
`ifdef REGFILE_BYPASS_EN
    push("bypass_rs2", 32'h12345678);
`else
    push("bypass_rs2", 32'h0);
`endif
    check(bus.rs2_data);
    tick();
    idle();
    push("after_wr3_rs2", 32'h12345678); check(bus.rs2_data);

    // Async reset clears contents before the next clock edge.
    bus.RegWEn0 = 1'b1; bus.rd0_addr = 5'd9; bus.rd0_data = 32'hFFFFFFFF;
    tick();
    idle();
    read_check(5'd9, 32'hFFFFFFFF, 1'b0, "wr9");
    rst_n = 1'b0;
    #1;
    push("async_rst_rs1", 32'h0); check(bus.rs1_data);
    push("async_rst_before_edge", 32'h1); check({31'b0, clk});
    rst_n = 1'b1;
    tick();
    read_check(5'd9, 32'h0, 1'b0, "post_async_rst9");
    read_check(5'd5, 32'h0, 1'b0, "post_async_rst5");

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
